// File: rtl/i2c_slave.sv
// +-------------------------------------------------------------------------+
// | i2c_slave : I2C target with filtered SCL/SDA, fixed 7-bit address match, |
// | ACK generation and pulse handshake to the local side.  Rev 1.0           |
// +-------------------------------------------------------------------------+
`default_nettype none

module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42,
  parameter int         FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rw,
  output logic       busy,
  output logic       start_det,
  output logic       stop_det,
  output logic       nack_rcvd
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK, S_IGNORE
  } state_t;

  localparam logic [3:0] c_FILT_MAX = 4'(FILTER_LEN - 1);

  logic       r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;
  logic       r_scl_f, r_sda_f, r_scl_d, r_sda_d;
  logic [3:0] r_scl_cnt, r_sda_cnt;

  state_t     r_state, w_state;
  logic [2:0] r_bit_cnt, w_bit_cnt;
  logic [6:0] r_shift, w_shift;
  logic [7:0] r_tx_sr, w_tx_sr, r_rx_data, w_rx_data;
  logic       r_rw, w_rw, r_busy, w_busy, r_sda_low, w_sda_low, r_pend, w_pend;
  logic       r_tx_req, w_tx_req, r_rx_valid, w_rx_valid;
  logic       r_start_det, w_start_det, r_stop_det, w_stop_det, r_nack, w_nack;

  logic w_scl_rise, w_scl_fall, w_start, w_stop;

  // A filtered level only follows the synchronized input after FILTER_LEN equal samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scl_s1  <= 1'b1;
      r_scl_s2  <= 1'b1;
      r_sda_s1  <= 1'b1;
      r_sda_s2  <= 1'b1;
      r_scl_f   <= 1'b1;
      r_sda_f   <= 1'b1;
      r_scl_d   <= 1'b1;
      r_sda_d   <= 1'b1;
      r_scl_cnt <= 4'd0;
      r_sda_cnt <= 4'd0;
    end else begin
      r_scl_s1 <= scl;
      r_scl_s2 <= r_scl_s1;
      r_sda_s1 <= sda;
      r_sda_s2 <= r_sda_s1;
      r_scl_d  <= r_scl_f;
      r_sda_d  <= r_sda_f;
      if (r_scl_s2 == r_scl_f) begin
        r_scl_cnt <= 4'd0;
      end else if (r_scl_cnt == c_FILT_MAX) begin
        r_scl_f   <= r_scl_s2;
        r_scl_cnt <= 4'd0;
      end else begin
        r_scl_cnt <= r_scl_cnt + 4'd1;
      end
      if (r_sda_s2 == r_sda_f) begin
        r_sda_cnt <= 4'd0;
      end else if (r_sda_cnt == c_FILT_MAX) begin
        r_sda_f   <= r_sda_s2;
        r_sda_cnt <= 4'd0;
      end else begin
        r_sda_cnt <= r_sda_cnt + 4'd1;
      end
    end
  end

  assign w_scl_rise = r_scl_f & ~r_scl_d;
  assign w_scl_fall = ~r_scl_f & r_scl_d;
  assign w_start    = r_scl_f & r_sda_d & ~r_sda_f;
  assign w_stop     = r_scl_f & ~r_sda_d & r_sda_f;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= 3'd7;
      r_shift     <= 7'd0;
      r_tx_sr     <= 8'h00;
      r_rx_data   <= 8'h00;
      r_rw        <= 1'b0;
      r_busy      <= 1'b0;
      r_sda_low   <= 1'b0;
      r_pend      <= 1'b0;
      r_tx_req    <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_start_det <= 1'b0;
      r_stop_det  <= 1'b0;
      r_nack      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_bit_cnt   <= w_bit_cnt;
      r_shift     <= w_shift;
      r_tx_sr     <= w_tx_sr;
      r_rx_data   <= w_rx_data;
      r_rw        <= w_rw;
      r_busy      <= w_busy;
      r_sda_low   <= w_sda_low;
      r_pend      <= w_pend;
      r_tx_req    <= w_tx_req;
      r_rx_valid  <= w_rx_valid;
      r_start_det <= w_start_det;
      r_stop_det  <= w_stop_det;
      r_nack      <= w_nack;
    end
  end

  // r_pend marks "byte finished, act on the next SCL fall" (ACK drive or ACK slot entry)
  always_comb begin
    w_state     = r_state;
    w_bit_cnt   = r_bit_cnt;
    w_shift     = r_shift;
    w_tx_sr     = r_tx_req ? tx_data : r_tx_sr;
    w_rx_data   = r_rx_data;
    w_rw        = r_rw;
    w_busy      = r_busy;
    w_sda_low   = r_sda_low;
    w_pend      = r_pend;
    w_tx_req    = 1'b0;
    w_rx_valid  = 1'b0;
    w_start_det = 1'b0;
    w_stop_det  = 1'b0;
    w_nack      = 1'b0;
    if (w_start) begin
      w_state     = S_ADDR;
      w_bit_cnt   = 3'd7;
      w_sda_low   = 1'b0;
      w_busy      = 1'b0;
      w_pend      = 1'b0;
      w_start_det = 1'b1;
    end else if (w_stop) begin
      w_state    = S_IDLE;
      w_sda_low  = 1'b0;
      w_busy     = 1'b0;
      w_pend     = 1'b0;
      w_stop_det = 1'b1;
    end else begin
      case (r_state)
        S_ADDR: begin
          if (w_scl_rise) begin
            w_shift = {r_shift[5:0], r_sda_f};
            if (r_bit_cnt == 3'd0) begin
              if (r_shift == SLAVE_ADDR) begin
                w_rw     = r_sda_f;
                w_busy   = 1'b1;
                w_tx_req = r_sda_f;
                w_pend   = 1'b1;
              end else begin
                w_state = S_IGNORE;
              end
            end else begin
              w_bit_cnt = r_bit_cnt - 3'd1;
            end
          end else if (w_scl_fall && r_pend) begin
            w_sda_low = 1'b1;
            w_pend    = 1'b0;
            w_state   = S_ADDR_ACK;
          end
        end
        S_ADDR_ACK: begin
          if (w_scl_fall) begin
            if (r_rw) begin
              w_sda_low = ~r_tx_sr[7];
              w_bit_cnt = 3'd6;
              w_state   = S_READ;
            end else begin
              w_sda_low = 1'b0;
              w_bit_cnt = 3'd7;
              w_state   = S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (w_scl_rise) begin
            w_shift = {r_shift[5:0], r_sda_f};
            if (r_bit_cnt == 3'd0) begin
              w_rx_data  = {r_shift, r_sda_f};
              w_rx_valid = 1'b1;
              w_pend     = 1'b1;
            end else begin
              w_bit_cnt = r_bit_cnt - 3'd1;
            end
          end else if (w_scl_fall && r_pend) begin
            w_sda_low = 1'b1;
            w_pend    = 1'b0;
            w_state   = S_WRITE_ACK;
          end
        end
        S_WRITE_ACK: begin
          if (w_scl_fall) begin
            w_sda_low = 1'b0;
            w_bit_cnt = 3'd7;
            w_state   = S_WRITE;
          end
        end
        S_READ: begin
          if (w_scl_fall) begin
            if (r_pend) begin
              w_sda_low = 1'b0;
              w_pend    = 1'b0;
              w_state   = S_READ_ACK;
            end else begin
              w_sda_low = ~r_tx_sr[r_bit_cnt];
              if (r_bit_cnt == 3'd0) w_pend = 1'b1;
              else w_bit_cnt = r_bit_cnt - 3'd1;
            end
          end
        end
        S_READ_ACK: begin
          if (w_scl_rise) begin
            if (!r_sda_f) begin
              w_tx_req = 1'b1;
              w_pend   = 1'b1;
            end else begin
              w_nack  = 1'b1;
              w_busy  = 1'b0;
              w_state = S_IGNORE;
            end
          end else if (w_scl_fall && r_pend) begin
            w_sda_low = ~r_tx_sr[7];
            w_bit_cnt = 3'd6;
            w_pend    = 1'b0;
            w_state   = S_READ;
          end
        end
        S_IGNORE: w_sda_low = 1'b0;
        default:  w_state = r_state;
      endcase
    end
  end

  assign sda       = r_sda_low ? 1'b0 : 1'bz;
  assign tx_req    = r_tx_req;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign rw        = r_rw;
  assign busy      = r_busy;
  assign start_det = r_start_det;
  assign stop_det  = r_stop_det;
  assign nack_rcvd = r_nack;

endmodule

`default_nettype wire

// File: tb/tb_i2c_slave.sv
// +-------------------------------------------------------------------------+
// | tb_i2c_slave : bit-banged I2C master with an event scoreboard. Rev 1.0   |
// +-------------------------------------------------------------------------+
`default_nettype none

module tb_i2c_slave;

  localparam int Q  = 10;
  localparam int FL = 3;

  typedef enum logic [2:0] {EV_START, EV_STOP, EV_RX, EV_TXREQ, EV_NACK} ev_t;
  typedef struct packed {
    ev_t        kind;
    logic [7:0] data;
  } ev_s;

  logic       clk, reset, scl, m_low;
  logic [7:0] tx_data;
  wire        sda;
  logic       tx_req, rx_valid, rw, busy, start_det, stop_det, nack_rcvd;
  logic [7:0] rx_data;

  ev_s  exp_q[$];
  int   total, bad;
  logic watch;
  int   drive_cnt;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave #(.SLAVE_ADDR(7'h42), .FILTER_LEN(FL)) dut (
    .clk(clk), .reset(reset), .scl(scl), .sda(sda), .tx_data(tx_data),
    .tx_req(tx_req), .rx_data(rx_data), .rx_valid(rx_valid), .rw(rw),
    .busy(busy), .start_det(start_det), .stop_det(stop_det), .nack_rcvd(nack_rcvd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input ev_t k, input logic [7:0] d);
    ev_s e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input ev_t k, input logic [7:0] d, input string nm);
    ev_s e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: unexpected pulse (data %0h), nothing expected", nm, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || (k == EV_RX && e.data != d)) begin
        bad++;
        $display("FAIL %s: got kind %0d data %0h expected kind %0d data %0h",
                 nm, k, d, e.kind, e.data);
      end
    end
  endtask

  // Monitor: every DUT pulse consumes one expected event
  always @(negedge clk) begin
    if (!reset) begin
      if (start_det) pop_cmp(EV_START, 8'h00, "start_det");
      if (stop_det)  pop_cmp(EV_STOP,  8'h00, "stop_det");
      if (rx_valid)  pop_cmp(EV_RX,    rx_data, "rx_valid");
      if (tx_req)    pop_cmp(EV_TXREQ, 8'h00, "tx_req");
      if (nack_rcvd) pop_cmp(EV_NACK,  8'h00, "nack_rcvd");
    end
  end

  always @(negedge clk) if (watch && !m_low && sda === 1'b0) drive_cnt++;

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_x(input logic b, input logic glitch, output logic s);
    m_low = ~b;
    wq(2*Q);
    scl = 1'b1;
    if (glitch) begin
      wq(4); scl = 1'b0; wq(FL-1); scl = 1'b1; wq(Q-4-(FL-1));
    end else begin
      wq(Q);
    end
    s = sda;
    wq(Q);
    scl = 1'b0;
  endtask

  task automatic start_c();
    m_low = 1'b0; wq(Q); scl = 1'b1; wq(2*Q); m_low = 1'b1; wq(2*Q); scl = 1'b0;
  endtask

  task automatic stop_c();
    m_low = 1'b1; wq(Q); scl = 1'b1; wq(2*Q); m_low = 1'b0; wq(2*Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, input logic glitch, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_x(d[i], glitch, s);
    bit_x(1'b1, 1'b0, ack);
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_x(1'b1, 1'b0, s);
      d[i] = s;
    end
    bit_x(nack, 1'b0, s);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic [7:0] d;
    total = 0; bad = 0; watch = 1'b0; drive_cnt = 0;
    reset = 1'b1; scl = 1'b1; m_low = 1'b0; tx_data = 8'h00;
    wq(5);
    check("rst_sda", sda, 1'b1);
    check("rst_busy", busy, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rw", rw, 0);
    check("rst_pulses", {tx_req, rx_valid, start_det, stop_det, nack_rcvd}, 5'b0);
    reset = 1'b0;
    wq(10);

    // Write 0xA5 to 0x42
    push(EV_START, 0); start_c();
    wr_byte(8'h84, 0, ack); check("wr_addr_ack", ack, 0);
    check("wr_rw", rw, 0); check("wr_busy", busy, 1);
    push(EV_RX, 8'hA5); wr_byte(8'hA5, 0, ack); check("wr_data_ack", ack, 0);
    push(EV_STOP, 0); stop_c();
    check("wr_busy_end", busy, 0); check("wr_rx_data", rx_data, 8'hA5);

    // Address mismatch
    watch = 1'b1; drive_cnt = 0;
    push(EV_START, 0); start_c();
    wr_byte(8'h86, 0, ack); check("mm_addr_nack", ack, 1); check("mm_busy", busy, 0);
    wr_byte(8'h11, 0, ack); check("mm_data_nack", ack, 1);
    push(EV_STOP, 0); stop_c();
    watch = 1'b0;
    check("mm_no_drive", drive_cnt, 0); check("mm_rx_data", rx_data, 8'hA5);

    // Read two bytes, ACK then NACK
    tx_data = 8'h3C;
    push(EV_START, 0); push(EV_TXREQ, 0); start_c();
    wr_byte(8'h85, 0, ack); check("rd_addr_ack", ack, 0); check("rd_rw", rw, 1);
    tx_data = 8'hC3;
    push(EV_TXREQ, 0); rd_byte(1'b0, d); check("rd_byte1", d, 8'h3C);
    push(EV_NACK, 0);  rd_byte(1'b1, d); check("rd_byte2", d, 8'hC3);
    check("rd_busy_nack", busy, 0);
    push(EV_STOP, 0); stop_c();

    // Write then repeated START into a read
    push(EV_START, 0); start_c();
    wr_byte(8'h84, 0, ack); check("sr_addr_ack", ack, 0); check("sr_rw0", rw, 0);
    push(EV_RX, 8'h07); wr_byte(8'h07, 0, ack); check("sr_data_ack", ack, 0);
    tx_data = 8'h96;
    push(EV_START, 0); push(EV_TXREQ, 0); start_c();
    check("sr_busy_cleared", busy, 0);
    wr_byte(8'h85, 0, ack); check("sr_addr2_ack", ack, 0); check("sr_rw1", rw, 1);
    push(EV_NACK, 0); rd_byte(1'b1, d); check("sr_rd_byte", d, 8'h96);
    check("sr_rx_data", rx_data, 8'h07);
    push(EV_STOP, 0); stop_c();

    // SCL glitches shorter than the filter on every bit
    push(EV_START, 0); start_c();
    wr_byte(8'h84, 0, ack); check("gl_addr_ack", ack, 0);
    push(EV_RX, 8'h5A); wr_byte(8'h5A, 1, ack); check("gl_data_ack", ack, 0);
    push(EV_STOP, 0); stop_c();
    check("gl_rx_data", rx_data, 8'h5A);

    // Reset while the slave drives a 0 read bit
    tx_data = 8'h00;
    push(EV_START, 0); push(EV_TXREQ, 0); start_c();
    wr_byte(8'h85, 0, ack); check("rr_addr_ack", ack, 0);
    m_low = 1'b0; wq(2*Q); scl = 1'b1; wq(2);
    check("rr_sda_driven", sda, 1'b0);
    #2 reset = 1'b1;
    #1 check("rr_sda_release", sda, 1'b1);
    wq(2);
    check("rr_busy", busy, 0); check("rr_rw", rw, 0); check("rr_rx_data", rx_data, 8'h00);
    check("rr_pulses", {tx_req, rx_valid, start_det, stop_det, nack_rcvd}, 5'b0);
    wq(3); reset = 1'b0; wq(10);
    scl = 1'b0; wq(Q);
    watch = 1'b1; drive_cnt = 0;
    wr_byte(8'h84, 0, ack); check("rr_idle_nack", ack, 1);
    watch = 1'b0;
    check("rr_idle_no_drive", drive_cnt, 0); check("rr_idle_busy", busy, 0);
    push(EV_START, 0); start_c();
    wr_byte(8'h84, 0, ack); check("rr_new_addr_ack", ack, 0);
    push(EV_RX, 8'h3C); wr_byte(8'h3C, 0, ack); check("rr_new_data_ack", ack, 0);
    push(EV_STOP, 0); stop_c();
    check("rr_new_rx_data", rx_data, 8'h3C);

    wq(5);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
